// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 types and command/response byte constants.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        WAIT_EDGE = 3'd3,
        DATA      = 3'd4,
        ACK       = 3'd5,
        WAIT_IDLE = 3'd6
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
    localparam logic [7:0] BREAK_PFX   = 8'hF0;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx_if
// Description : Command handshake and open-drain PS/2 line bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_done;
    logic       tx_err;

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err
    );

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : 2-FF synchroniser, FILTER_LEN-sample debounce, fall strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          meta_q, sync_q, level_q, fall_q;
    logic [CW-1:0] cnt_q;

    // Synchroniser and filtered level idle high so reset never produces a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            fall_q <= 1'b0;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync_q;
                fall_q  <= level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter with ACK check.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 130000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e    state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    bit_q, bit_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          drv_q, drv_d;
    logic          ok_q, ok_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          dmeta_q, dsync_q;
    logic          clk_level, clk_fall, timed;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (bus.ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            inh_q   <= '0;
            tmo_q   <= '0;
            drv_q   <= 1'b0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dmeta_q <= 1'b1;
            dsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            inh_q   <= inh_d;
            tmo_q   <= tmo_d;
            drv_q   <= drv_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dmeta_q <= bus.ps2_data_in;
            dsync_q <= dmeta_q;
        end
    end

    assign timed = (state_q inside {WAIT_EDGE, DATA, ACK, WAIT_IDLE});

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        bit_d   = bit_q;
        inh_d   = inh_q;
        drv_d   = drv_q;
        ok_d    = ok_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = (timed && tmo_q != TW'(TIMEOUT_CYCLES)) ? tmo_q + 1'b1 : tmo_q;

        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    data_d  = bus.tx_data;
                    par_d   = odd_parity(bus.tx_data);
                    bit_d   = '0;
                    inh_d   = '0;
                    tmo_d   = '0;
                    ok_d    = 1'b0;
                    drv_d   = 1'b0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) state_d = RTS;
                else                                  inh_d   = inh_q + 1'b1;
            end
            RTS: begin
                tmo_d   = '0;
                state_d = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                if (clk_fall) begin
                    bit_d   = 4'd1;
                    drv_d   = ~data_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                // bit_q holds the number of falls seen so far (1..9)
                if (clk_fall) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        drv_d = ~data_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        drv_d = ~par_q;
                    end else begin
                        drv_d   = 1'b0;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    bit_d   = 4'd11;
                    ok_d    = ~dsync_q;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && dsync_q) begin
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout overrides whatever the frame logic decided this cycle.
        if (timed && tmo_d == TW'(TIMEOUT_CYCLES)) begin
            done_d  = 1'b0;
            err_d   = 1'b1;
            drv_d   = 1'b0;
            state_d = IDLE;
        end
    end

    assign bus.tx_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.ps2_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
    assign bus.ps2_data_oe = (state_q == RTS) || (state_q == WAIT_EDGE) ||
                             ((state_q == DATA) && drv_q);
    assign bus.tx_done     = done_q;
    assign bus.tx_err      = err_q;
endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It is the outbound counterpart of the keyboard receive/keycode path. It drives the open-drain PS/2 clock and data lines through output-enable signals, generates the request-to-send sequence, shifts the frame out on device clock edges and checks the device ACK bit. It sits beside the PS/2 receiver in the keyboard subsystem. The top level performs tri-state resolution: line = oe ? 0 : Z.

Parameters:
INHIBIT_CYCLES, 6500, number of cycles ps2_clk is held low before RTS (100 us at 65 MHz).
TIMEOUT_CYCLES, 130000, maximum cycles from clock release to frame completion (2 ms at 65 MHz).
FILTER_LEN, 8, number of consecutive identical samples required to accept a new ps2_clk level.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_data  in  8  command byte
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high only in IDLE; the transfer is accepted when tx_valid && tx_ready
busy  out  1  ~tx_ready; the receiver ignores line activity while this is high
ps2_clk_in  in  1  raw asynchronous PS/2 clock line
ps2_data_in  in  1  raw asynchronous PS/2 data line
ps2_clk_oe  out  1  1 = pull clock low
ps2_data_oe  out  1  1 = pull data low
tx_done  out  1  1-cycle pulse: frame sent and ACK received
tx_err  out  1  1-cycle pulse: NACK or timeout

Behaviour:
- Reset values: state IDLE; tx_ready=1; busy=0; both oe=0; tx_done=0; tx_err=0; all counters 0. Reset mid-transfer releases both lines on the next edge; no pulse is emitted.
- Input conditioning: 2-FF synchroniser on both lines.
- ps2_clk level filter: the filtered level changes only after FILTER_LEN identical consecutive samples. fall = filtered 1->0 transition, 1-cycle strobe.
- Acceptance: latch tx_data; parity = ~^tx_data (odd parity); bit counter = 0. tx_valid is ignored while busy; no queuing.
- INHIBIT state:
  - clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, starting the cycle after acceptance.
  - The following cycle is RTS: clk_oe=1, data_oe=1 (start bit), for 1 cycle.
- WAIT_EDGE state: clk_oe=0, data_oe=1; the timeout counter starts here.
- DATA state (each fall increments the bit counter and drives the next bit):
  - Falls 1..8 drive data_oe = ~tx_data[n-1], LSB first.
  - Fall 9 drives data_oe = ~parity.
  - Fall 10 sets data_oe=0 (stop bit = released line).
- ACK state: on fall 11, sample synchronised data.
  - 0 = ACK, ok flag set.
  - 1 = NACK, error flag set.
- WAIT_IDLE state: wait until filtered clk=1 and synced data=1. Then go to IDLE and pulse tx_done (ok) or tx_err (NACK) in the same cycle tx_ready rises.
- Timeout:
  - Counter reaches TIMEOUT_CYCLES in any state from WAIT_EDGE through WAIT_IDLE: release both oe, pulse tx_err, go to IDLE.
  - Timeout has priority over a simultaneous fall.
- tx_done and tx_err are never asserted together.
- Counter widths: $clog2(param+1), saturating. No wrap-around is possible.

Decomposition:
- ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, WAIT_EDGE, DATA, ACK, WAIT_IDLE)
  - command constants: CMD_SET_LED 8'hED, CMD_RESET 8'hFF, CMD_ENABLE 8'hF4
  - response constants: RSP_ACK 8'hFA, RSP_BAT_OK 8'hAA
  - break prefix 8'hF0
- Sub-module ps2_line_filter: synchroniser + FILTER_LEN debounce + fall strobe. It is reused by the receiver.

Test Plan:
- Command 0xED; device model clocks at 10 kHz, samples on rising edges and ACKs:
  - Model captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses exactly once; tx_err stays 0.
- Accept 0x55: clk_oe high exactly 6500 cycles, then 1 RTS cycle with both oe=1, then clk_oe=0 and data_oe=1. tx_ready stays 0 from acceptance onward; a second tx_valid during this time is ignored.
- No device response after RTS: exactly TIMEOUT_CYCLES after clock release, tx_err pulses once, both oe=0, tx_ready=1.
- Device holds data high at fall 11 (NACK) for 0xF4: tx_err pulses after the lines idle; no tx_done.
- 3-cycle low glitch on ps2_clk_in during DATA: bit counter and data_oe unchanged. A 20-cycle low pulse advances exactly one bit.
- Assert rst after fall 4 of 0xFF: the next cycle shows clk_oe=0, data_oe=0, tx_ready=1 and no pulses. A fresh 0xFF then completes with tx_done.
